// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, datapath
// mux selects, ALUOp values, the sequencer state enum and the control word.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;

  // Must match the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALU_LUI    = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_BRANCH = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_ADD    = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_SW     = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_ADDI   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_ORI    = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_ANDI   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_RTYPE  = 3'b111;

  localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PC_RS     = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_RT      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] RD_RT = 2'b00;
  localparam logic [SEL_W-1:0] RD_RD = 2'b01;
  localparam logic [SEL_W-1:0] RD_RA = 2'b10;

  localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_RST_IDLE = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  typedef struct packed {
    logic               mem_req;
    logic               mem_write;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic [SEL_W-1:0]   pc_source;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               reg_write;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   mem_to_reg;
    logic               illegal;
  } ctrl_word_t;

  // ALU operation for the immediate-arithmetic group; LUI is the fallback
  function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI: imm_alu_op = ALU_ADDI;
      OP_ANDI: imm_alu_op = ALU_ANDI;
      OP_ORI:  imm_alu_op = ALU_ORI;
      default: imm_alu_op = ALU_LUI;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state/opcode to control-word decoder for the multi-cycle
// sequencer. FETCH strobes are emitted ungated; the top qualifies them.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_zero,
  output ctrl_word_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_ALU;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
      end
      // Speculative branch target into ALUOut
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RD;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = imm_alu_op(i_opcode);
      end
      S_WB_I: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_opcode == OP_SW) ? ALU_SW : ALU_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.iord    = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RD_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_BRANCH;
        o_ctrl.pc_source = PC_ALUOUT;
        o_ctrl.pc_write  = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
      end
      // PC already holds PC+4 here, so JAL links straight from the PC
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_JUMP;
        if (i_opcode == OP_JAL) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = RD_RA;
          o_ctrl.mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_RS;
      end
      S_TRAP:  o_ctrl.illegal = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main sequencer for the multi-cycle MIPS datapath: state register, opcode
// dispatch and memory handshake, with control outputs decoded from state.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      opcode,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [SEL_W-1:0]     PCSource,
  output logic                 ALUSrcA,
  output logic [SEL_W-1:0]     ALUSrcB,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic                 RegWrite,
  output logic [SEL_W-1:0]     RegDst,
  output logic [SEL_W-1:0]     MemtoReg,
  output logic                 illegal
);

  state_t     r_state;
  state_t     w_next_state;
  ctrl_word_t w_ctrl;
  ctrl_word_t w_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST_IDLE: w_next_state = S_FETCH;
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                       w_next_state = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                   w_next_state = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
          OP_BEQ, OP_BNE:                 w_next_state = S_BRANCH;
          OP_J, OP_JAL:                   w_next_state = S_JUMP;
          default:                        w_next_state = S_TRAP;
        endcase
      end
      S_EXEC_R:   w_next_state = S_WB_R;
      S_EXEC_I:   w_next_state = S_WB_I;
      S_MEM_ADDR: w_next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next_state = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_RST_IDLE;
    endcase
  end

  ctrl_output_decode u_decode (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_ctrl   (w_ctrl)
  );

  // PC and IR only load on the cycle the instruction fetch completes
  always_comb begin
    w_out = w_ctrl;
    if (r_state == S_FETCH) begin
      w_out.pc_write = w_ctrl.pc_write & mem_ready;
      w_out.ir_write = w_ctrl.ir_write & mem_ready;
    end
  end

  assign mem_req   = w_out.mem_req;
  assign mem_write = w_out.mem_write;
  assign IorD      = w_out.iord;
  assign IRWrite   = w_out.ir_write;
  assign PCWrite   = w_out.pc_write;
  assign PCSource  = w_out.pc_source;
  assign ALUSrcA   = w_out.alu_src_a;
  assign ALUSrcB   = w_out.alu_src_b;
  assign ALUOp     = w_out.alu_op;
  assign RegWrite  = w_out.reg_write;
  assign RegDst    = w_out.reg_dst;
  assign MemtoReg  = w_out.mem_to_reg;
  assign illegal   = w_out.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class
// cycle by cycle and compares the full control bundle to hand-built words.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, IorD, IRWrite, PCWrite, ALUSrcA, RegWrite, illegal;
  logic [1:0] PCSource, ALUSrcB, RegDst, MemtoReg;
  logic [2:0] ALUOp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSource  (PCSource),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .RegWrite  (RegWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .illegal   (illegal)
  );

  // {mem_req,mem_write,IorD,IRWrite,PCWrite,PCSource,ALUSrcA,ALUSrcB,ALUOp,RegWrite,RegDst,MemtoReg,illegal}
  logic [18:0] obs_cw;
  assign obs_cw = {mem_req, mem_write, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
                   ALUSrcB, ALUOp, RegWrite, RegDst, MemtoReg, illegal};

  localparam logic [18:0] CW_ZERO     = 19'b0_0_0_0_0_00_0_00_000_0_00_00_0;
  localparam logic [18:0] CW_FETCH    = 19'b1_0_0_1_1_00_0_01_010_0_00_00_0;
  localparam logic [18:0] CW_FWAIT    = 19'b1_0_0_0_0_00_0_01_010_0_00_00_0;
  localparam logic [18:0] CW_DECODE   = 19'b0_0_0_0_0_00_0_11_010_0_00_00_0;
  localparam logic [18:0] CW_EXEC_R   = 19'b0_0_0_0_0_00_1_00_111_0_00_00_0;
  localparam logic [18:0] CW_WB_R     = 19'b0_0_0_0_0_00_0_00_000_1_01_00_0;
  localparam logic [18:0] CW_EXEC_ORI = 19'b0_0_0_0_0_00_1_10_101_0_00_00_0;
  localparam logic [18:0] CW_WB_I     = 19'b0_0_0_0_0_00_0_00_000_1_00_00_0;
  localparam logic [18:0] CW_ADDR_LW  = 19'b0_0_0_0_0_00_1_10_010_0_00_00_0;
  localparam logic [18:0] CW_ADDR_SW  = 19'b0_0_0_0_0_00_1_10_011_0_00_00_0;
  localparam logic [18:0] CW_MEM_RD   = 19'b1_0_1_0_0_00_0_00_000_0_00_00_0;
  localparam logic [18:0] CW_MEM_WR   = 19'b1_1_1_0_0_00_0_00_000_0_00_00_0;
  localparam logic [18:0] CW_WB_MEM   = 19'b0_0_0_0_0_00_0_00_000_1_00_01_0;
  localparam logic [18:0] CW_BR_TAKE  = 19'b0_0_0_0_1_01_1_00_001_0_00_00_0;
  localparam logic [18:0] CW_BR_NOT   = 19'b0_0_0_0_0_01_1_00_001_0_00_00_0;
  localparam logic [18:0] CW_JAL      = 19'b0_0_0_0_1_10_0_00_000_1_10_10_0;
  localparam logic [18:0] CW_J        = 19'b0_0_0_0_1_10_0_00_000_0_00_00_0;
  localparam logic [18:0] CW_JR       = 19'b0_0_0_0_1_11_0_00_000_0_00_00_0;
  localparam logic [18:0] CW_TRAP     = 19'b0_0_0_0_0_00_0_00_000_0_00_00_1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    #1;
    n_cmp++;
    assert (obs_cw === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs_cw, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    chk("reset_t0", CW_ZERO);
    tick(); chk("reset_held", CW_ZERO);
    reset = 1'b1;
    chk("rst_idle", CW_ZERO);

    // R-type ADD, no wait states
    tick(); chk("r_fetch", CW_FETCH);
    tick(); chk("r_decode", CW_DECODE);
    tick(); chk("r_exec", CW_EXEC_R);
    tick(); chk("r_wb", CW_WB_R);

    // LW with two wait cycles in FETCH and in MEM_RD
    tick(); opcode = 6'h23; mem_ready = 1'b0; chk("lw_fwait0", CW_FWAIT);
    tick(); chk("lw_fwait1", CW_FWAIT);
    tick(); mem_ready = 1'b1; chk("lw_fetch", CW_FETCH);
    tick(); chk("lw_decode", CW_DECODE);
    tick(); chk("lw_addr", CW_ADDR_LW);
    tick(); mem_ready = 1'b0; chk("lw_rd_wait0", CW_MEM_RD);
    tick(); chk("lw_rd_wait1", CW_MEM_RD);
    tick(); mem_ready = 1'b1; chk("lw_rd_done", CW_MEM_RD);
    tick(); chk("lw_wb", CW_WB_MEM);

    // BEQ taken
    tick(); opcode = 6'h04; zero = 1'b1; chk("beq_fetch", CW_FETCH);
    tick(); chk("beq_decode", CW_DECODE);
    tick(); chk("beq_branch", CW_BR_TAKE);

    // BNE with zero=1 not taken, then zero=0 taken
    tick(); opcode = 6'h05; chk("bne_fetch", CW_FETCH);
    tick(); chk("bne_decode", CW_DECODE);
    tick(); chk("bne_zero1", CW_BR_NOT);
    zero = 1'b0; chk("bne_zero0", CW_BR_TAKE);

    // JAL, J, JR
    tick(); opcode = 6'h03; chk("jal_fetch", CW_FETCH);
    tick(); chk("jal_decode", CW_DECODE);
    tick(); chk("jal_jump", CW_JAL);
    tick(); opcode = 6'h02; chk("j_fetch", CW_FETCH);
    tick(); chk("j_decode", CW_DECODE);
    tick(); chk("j_jump", CW_J);
    tick(); opcode = 6'h00; funct = 6'h08; chk("jr_fetch", CW_FETCH);
    tick(); chk("jr_decode", CW_DECODE);
    tick(); chk("jr_exec", CW_JR);

    // ORI
    tick(); opcode = 6'h0D; funct = 6'h00; chk("ori_fetch", CW_FETCH);
    tick(); chk("ori_decode", CW_DECODE);
    tick(); chk("ori_exec", CW_EXEC_ORI);
    tick(); chk("ori_wb", CW_WB_I);

    // SW, no wait states: back to FETCH after four cycles
    tick(); opcode = 6'h2B; chk("sw_fetch", CW_FETCH);
    tick(); chk("sw_decode", CW_DECODE);
    tick(); chk("sw_addr", CW_ADDR_SW);
    tick(); chk("sw_wr", CW_MEM_WR);

    // Unsupported opcode traps and holds
    tick(); opcode = 6'h3F; chk("trap_fetch", CW_FETCH);
    tick(); chk("trap_decode", CW_DECODE);
    for (int i = 0; i < 20; i++) begin
      tick(); mem_ready = i[0]; chk("trap_hold", CW_TRAP);
    end
    reset = 1'b0; chk("trap_reset", CW_ZERO);
    tick(); reset = 1'b1; mem_ready = 1'b1; chk("trap_rst_idle", CW_ZERO);

    // Reset while MEM_WR waits on memory
    tick(); opcode = 6'h2B; chk("swr_fetch", CW_FETCH);
    tick(); chk("swr_decode", CW_DECODE);
    tick(); mem_ready = 1'b0; chk("swr_addr", CW_ADDR_SW);
    tick(); chk("swr_wait0", CW_MEM_WR);
    tick(); chk("swr_wait1", CW_MEM_WR);
    reset = 1'b0; chk("swr_reset_async", CW_ZERO);
    tick(); chk("swr_reset_held", CW_ZERO);
    reset = 1'b1; chk("swr_rst_idle", CW_ZERO);
    tick(); chk("swr_refetch", CW_FWAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Main sequencer for the multi-cycle MIPS datapath. Walks each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath enable and mux select, plus the 3-bit ALUOp consumed by the ALU control decoder. Owns the single shared instruction/data memory port through a req/ready handshake.

## Interface
- No parameters. Encodings are fixed constants in the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0], used only to detect JR
- zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_write  out  1  with mem_req: 1 = store, 0 = read
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the instruction register
- PCWrite  out  1  unconditional PC load
- PCSource  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  3  111 R-type, 001 branch, 100 ADDI, 101 ORI, 110 ANDI, 000 LUI, 010 LW/add, 011 SW
- RegWrite  out  1  register file write enable
- RegDst  out  2  destination select: 00 = rt, 01 = rd, 10 = $31
- MemtoReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
- illegal  out  1  sticky flag for an unsupported opcode

## Operation
- All outputs are Moore-decoded from the state register.
  - Exception: in FETCH, PCWrite and IRWrite are gated by mem_ready.
  - Outputs not listed for a state are 0.
- Supported opcodes: 0x00 R-type, 0x02 J, 0x03 JAL, 0x04 BEQ, 0x05 BNE, 0x08 ADDI, 0x0C ANDI, 0x0D ORI, 0x0F LUI, 0x23 LW, 0x2B SW.
- State behaviour:
  - RST_IDLE: all outputs 0. Always goes to FETCH.
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00.
    - mem_ready=1 → IRWrite=1, PCWrite=1, go to DECODE.
    - Otherwise stay in FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=010 (branch target into ALUOut). Dispatch by opcode:
    - R-type with funct=0x08 → JR; other R-type → EXEC_R.
    - LW/SW → MEM_ADDR.
    - ADDI/ANDI/ORI/LUI → EXEC_I.
    - BEQ/BNE → BRANCH.
    - J/JAL → JUMP.
    - Anything else → TRAP.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111 → WB_R.
  - WB_R: RegWrite=1, RegDst=01, MemtoReg=00 → FETCH.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp from opcode (100/110/101/000) → WB_I.
  - WB_I: RegWrite=1, RegDst=00, MemtoReg=00 → FETCH.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=010 for LW / 011 for SW. Next state MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: mem_req=1, IorD=1. Leaves for WB_MEM on mem_ready.
  - MEM_WR: mem_req=1, mem_write=1, IorD=1. Leaves for FETCH on mem_ready.
  - WB_MEM: RegWrite=1, RegDst=00, MemtoReg=01 → FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01.
    - PCWrite = zero for BEQ, ~zero for BNE.
    - Next state FETCH.
  - JUMP: PCWrite=1, PCSource=10.
    - For JAL also RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4).
    - Next state FETCH.
  - JR: PCWrite=1, PCSource=11 → FETCH.
  - TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- Memory handshake rules:
  - mem_req, mem_write and IorD stay stable while waiting; there is no timeout.
  - mem_ready while mem_req=0 is ignored.

## Timing
- Reset assert: immediately (asynchronously) forces RST_IDLE, so every output is 0, including illegal.
  - This also applies mid-instruction or mid-handshake; the in-flight memory access is abandoned.
- First mem_req rises one cycle after reset deasserts.
- Instruction latency with zero memory wait states (FETCH through the last state, inclusive):
  - R-type and I-type ALU: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE, J/JAL, JR: 3 cycles.
- Each wait cycle (mem_ready=0 while mem_req=1) adds exactly one cycle.
- A PC or register write takes effect on the rising edge that ends the asserting state.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants and the JR funct constant;
  - ALUOp encodings (must match the ALU control decoder);
  - PCSource, RegDst and MemtoReg encodings;
  - the state enum.
- Sub-module ctrl_output_decode: combinational state/opcode → control word. The top keeps the state register, next-state logic and mem_ready gating.

## Test plan
- Reset released, opcode=0x00, funct=0x20, mem_ready=1 → FETCH, DECODE, EXEC_R (ALUOp=111), WB_R (RegWrite=1, RegDst=01), back in FETCH on cycle 5.
- LW (0x23) with mem_ready low for 2 cycles in both FETCH and MEM_RD → 9 cycles total; mem_req/IorD stable while waiting; WB_MEM has MemtoReg=01.
- BEQ with zero=1 gives PCWrite=1; BNE with zero=1 gives PCWrite=0. Both use ALUOp=001, PCSource=01, 3 cycles.
- JAL (0x03) → JUMP with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; JR (0x00, funct 0x08) → PCSource=11.
- Opcode 0x3F → TRAP, illegal=1 held for 20 cycles; reset then clears it and all outputs to 0.
- Reset asserted in MEM_WR while waiting on mem_ready → all outputs 0 in the same cycle; FETCH resumes one cycle after release.
